// File: rtl/vfu_rsp_bridge.sv
// vfu_rsp_bridge: in-order CFU command/response bridge with result buffering, watchdog and sticky errors
module vfu_rsp_bridge #(
  parameter int INSN_WIDTH = 32,
  parameter int VEX_DATA_WIDTH = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int RSP_DEPTH = 2,
  parameter logic [2:0] RD_FUNCT3 = 3'b111,
  parameter logic [VEX_DATA_WIDTH-1:0] ACK_VALUE = '0,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter logic [VEX_DATA_WIDTH-1:0] TIMEOUT_VALUE = 32'hDEADBEEF
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     cmd_valid,
  output logic                                     cmd_ready,
  input  logic [INSN_WIDTH-1:0]                    cmd_payload_instruction,
  input  logic [VEX_DATA_WIDTH-1:0]                cmd_payload_inputs_0,
  input  logic [VEX_DATA_WIDTH-1:0]                cmd_payload_inputs_1,
  output logic                                     rsp_valid,
  input  logic                                     rsp_ready,
  output logic [VEX_DATA_WIDTH-1:0]                rsp_payload_output,
  output logic                                     core_insn_valid,
  output logic [INSN_WIDTH-1:0]                    core_insn,
  output logic [VEX_DATA_WIDTH-1:0]                core_data_0,
  output logic [VEX_DATA_WIDTH-1:0]                core_data_1,
  input  logic                                     core_rdy,
  input  logic                                     core_res_valid,
  input  logic [VEX_DATA_WIDTH-1:0]                core_res_data,
  output logic                                     err_spurious,
  output logic                                     err_timeout,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     stat_outstanding
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int RW = RSP_DEPTH > 1 ? $clog2(RSP_DEPTH) : 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES + 2);
  logic [MAX_OUTSTANDING-1:0] pq_mem;
  logic [PW-1:0] pq_wp, pq_rp;
  logic [OW-1:0] pq_cnt, rcnt, rb_cnt;
  logic [VEX_DATA_WIDTH-1:0] rb_mem [RSP_DEPTH];
  logic [RW-1:0] rb_wp, rb_rp;
  logic [WW-1:0] wd;
  logic is_r, acc, acc_r, head_r, tmo, pop, pop_r, rb_push, rb_pop;
  assign is_r = cmd_payload_instruction[14:12] == RD_FUNCT3;
  assign cmd_ready = ~reset & core_rdy & (pq_cnt != OW'(MAX_OUTSTANDING)) & ~(is_r & (rcnt == OW'(RSP_DEPTH)));
  assign acc = cmd_valid & cmd_ready;
  assign acc_r = acc & is_r;
  assign core_insn_valid = acc;
  assign core_insn = cmd_payload_instruction;
  assign core_data_0 = cmd_payload_inputs_0;
  assign core_data_1 = cmd_payload_inputs_1;
  assign head_r = (pq_cnt != '0) & pq_mem[pq_rp];
  assign tmo = head_r && TIMEOUT_CYCLES != 0 && wd == WW'(TIMEOUT_CYCLES);
  assign rsp_valid = (pq_cnt != '0) & (~head_r | tmo | (rb_cnt != '0));
  assign rsp_payload_output = ~rsp_valid ? '0 : ~head_r ? ACK_VALUE : tmo ? TIMEOUT_VALUE : rb_mem[rb_rp];
  assign pop = rsp_valid & rsp_ready;
  assign pop_r = pop & head_r;
  assign rb_pop = pop_r & (rb_cnt != '0);
  assign rb_push = core_res_valid & (rb_cnt < rcnt);
  assign stat_outstanding = pq_cnt;
  // queue storage: command class per pending slot and buffered core results
  always_ff @(posedge clk) begin
    if (acc) pq_mem[pq_wp] <= is_r;
    if (rb_push) rb_mem[rb_wp] <= core_res_data;
  end
  // pointers, occupancy, credit, watchdog and sticky error flags
  always_ff @(posedge clk)
    if (reset) begin
      pq_wp <= '0;
      pq_rp <= '0;
      pq_cnt <= '0;
      rcnt <= '0;
      rb_wp <= '0;
      rb_rp <= '0;
      rb_cnt <= '0;
      wd <= '0;
      err_spurious <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      pq_wp <= pq_wp + PW'(acc);
      pq_rp <= pq_rp + PW'(pop);
      pq_cnt <= pq_cnt + OW'(acc) - OW'(pop);
      rcnt <= rcnt + OW'(acc_r) - OW'(pop_r);
      rb_wp <= rb_push ? (rb_wp == RW'(RSP_DEPTH - 1) ? '0 : rb_wp + RW'(1)) : rb_wp;
      rb_rp <= rb_pop ? (rb_rp == RW'(RSP_DEPTH - 1) ? '0 : rb_rp + RW'(1)) : rb_rp;
      rb_cnt <= rb_cnt + OW'(rb_push) - OW'(rb_pop);
      wd <= (pop || !head_r || TIMEOUT_CYCLES == 0) ? '0 : tmo ? wd : (rb_cnt != '0) ? '0 : wd + WW'(1);
      err_spurious <= err_spurious | (core_res_valid & ~rb_push);
      err_timeout <= err_timeout | tmo;
    end
endmodule

// File: tb/tb_vfu_rsp_bridge.sv
// tb_vfu_rsp_bridge: queue-model scoreboard plus directed scenarios for vfu_rsp_bridge
module tb_vfu_rsp_bridge;
  localparam int TMO = 16;
  localparam logic [31:0] A_INSN = 32'h0000_0057;
  localparam logic [31:0] R_INSN = 32'h0000_7057;
  logic clk = 1'b0, reset = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [31:0] cmd_payload_instruction = '0, cmd_payload_inputs_0 = '0, cmd_payload_inputs_1 = '0;
  logic rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_payload_output;
  logic core_insn_valid;
  logic [31:0] core_insn, core_data_0, core_data_1;
  logic core_rdy = 1'b1, core_res_valid = 1'b0;
  logic [31:0] core_res_data = '0;
  logic err_spurious, err_timeout;
  logic [2:0] stat_outstanding;
  int n_cmp = 0, n_bad = 0;
  bit started = 0;

  vfu_rsp_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_payload_instruction(cmd_payload_instruction), .cmd_payload_inputs_0(cmd_payload_inputs_0),
    .cmd_payload_inputs_1(cmd_payload_inputs_1), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_payload_output(rsp_payload_output), .core_insn_valid(core_insn_valid), .core_insn(core_insn),
    .core_data_0(core_data_0), .core_data_1(core_data_1), .core_rdy(core_rdy),
    .core_res_valid(core_res_valid), .core_res_data(core_res_data), .err_spurious(err_spurious),
    .err_timeout(err_timeout), .stat_outstanding(stat_outstanding));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: one entry per outstanding command, results fill the oldest unfilled R entry
  typedef struct {bit r; bit f; logic [31:0] d;} ent_t;
  ent_t q[$];
  int stall = 0, n_r;
  bit es = 0, et = 0, e_v, e_rdy, e_tm, pp, ac, found, insn_r;
  logic [31:0] e_pl;

  always @(negedge clk) begin
    #2;
    n_r = 0;
    foreach (q[i]) n_r += int'(q[i].r);
    insn_r = cmd_payload_instruction[14:12] == 3'b111;
    e_tm = q.size() > 0 && q[0].r && stall >= TMO;
    e_v = q.size() > 0 && (!q[0].r || e_tm || q[0].f);
    e_pl = !e_v ? 32'h0 : !q[0].r ? 32'h0 : e_tm ? 32'hDEADBEEF : q[0].d;
    e_rdy = !reset && core_rdy && q.size() < 4 && !(insn_r && n_r == 2);
    if (started) begin
      chk("rsp_valid", rsp_valid, e_v);
      chk("rsp_payload", rsp_payload_output, e_pl);
      chk("cmd_ready", cmd_ready, e_rdy);
      chk("core_insn_valid", core_insn_valid, cmd_valid && e_rdy);
      chk("core_insn", core_insn, cmd_payload_instruction);
      chk("core_data_0", core_data_0, cmd_payload_inputs_0);
      chk("stat_outstanding", stat_outstanding, q.size());
      chk("err_spurious", err_spurious, es);
      chk("err_timeout", err_timeout, et);
    end
    if (reset) begin
      q.delete();
      stall = 0;
      es = 0;
      et = 0;
    end else begin
      pp = e_v && rsp_ready;
      ac = cmd_valid && e_rdy;
      if (pp) stall = 0;
      else if (e_tm) stall = stall;
      else if (q.size() > 0 && q[0].r && !q[0].f) stall++;
      else stall = 0;
      et |= e_tm;
      if (core_res_valid) begin
        found = 0;
        foreach (q[i]) if (!found && q[i].r && !q[i].f) begin q[i].f = 1; q[i].d = core_res_data; found = 1; end
        if (!found) es = 1;
      end
      if (pp) void'(q.pop_front());
      if (ac) q.push_back('{r: insn_r, f: 1'b0, d: 32'h0});
    end
  end

  task automatic send(input logic [31:0] insn);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_payload_instruction = insn;
    cmd_payload_inputs_0 = insn ^ 32'hA5A5_0000;
    cmd_payload_inputs_1 = insn ^ 32'h0000_5A5A;
    #1;
    while (!cmd_ready && n < 30) begin @(negedge clk); #1; n++; end
    chk("send_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_payload_instruction = '0;
    cmd_payload_inputs_0 = '0;
    cmd_payload_inputs_1 = '0;
  endtask

  task automatic pulse(input logic [31:0] d);
    core_res_valid = 1'b1;
    core_res_data = d;
    @(negedge clk);
    core_res_valid = 1'b0;
    core_res_data = '0;
  endtask

  task automatic drain();
    int n = 0;
    rsp_ready = 1'b1;
    while (stat_outstanding != 0 && n < 40) begin @(negedge clk); n++; end
    chk("drain_empty", stat_outstanding, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] got[$];
    int n;
    @(negedge clk);
    @(negedge clk);
    started = 1;
    #1;
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_stat", stat_outstanding, 0);
    chk("reset_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    // core not ready blocks acceptance
    core_rdy = 1'b0;
    cmd_valid = 1'b1;
    cmd_payload_instruction = A_INSN;
    #1 chk("core_rdy_low", cmd_ready, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    core_rdy = 1'b1;
    // T1: A-cmd answered the cycle after accept
    rsp_ready = 1'b1;
    send(A_INSN);
    #1;
    chk("t1_valid", rsp_valid, 1);
    chk("t1_payload", rsp_payload_output, 32'h0);
    chk("t1_stat1", stat_outstanding, 1);
    @(negedge clk);
    #1;
    chk("t1_stat0", stat_outstanding, 0);
    chk("t1_valid_gone", rsp_valid, 0);
    // T2: R-cmd waits for the core result
    @(negedge clk);
    send(R_INSN);
    #1 chk("t2_wait_valid", rsp_valid, 0);
    repeat (4) @(negedge clk);
    pulse(32'h1234_5678);
    #1;
    chk("t2_valid", rsp_valid, 1);
    chk("t2_payload", rsp_payload_output, 32'h1234_5678);
    @(negedge clk);
    #1 chk("t2_stat0", stat_outstanding, 0);
    // T3: A,R,A with backpressure, in-order delivery
    @(negedge clk);
    rsp_ready = 1'b0;
    send(A_INSN);
    send(R_INSN);
    send(A_INSN);
    pulse(32'h0000_CAFE);
    repeat (6) begin
      #1;
      chk("t3_hold_valid", rsp_valid, 1);
      chk("t3_hold_payload", rsp_payload_output, 32'h0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    n = 0;
    while (got.size() < 3 && n < 20) begin
      #1;
      if (rsp_valid) got.push_back(rsp_payload_output);
      @(negedge clk);
      n++;
    end
    chk("t3_count", got.size(), 3);
    if (got.size() == 3) begin
      chk("t3_rsp0", got[0], 32'h0);
      chk("t3_rsp1", got[1], 32'h0000_CAFE);
      chk("t3_rsp2", got[2], 32'h0);
    end
    // T4a: result-credit limit on R-cmds
    rsp_ready = 1'b0;
    send(R_INSN);
    send(R_INSN);
    cmd_valid = 1'b1;
    cmd_payload_instruction = R_INSN;
    #1 chk("t4_r_credit", cmd_ready, 0);
    @(negedge clk);
    #1 chk("t4_r_credit2", cmd_ready, 0);
    @(negedge clk);
    pulse(32'h0000_0111);
    rsp_ready = 1'b1;
    #1 chk("t4_r_head_payload", rsp_payload_output, 32'h0000_0111);
    @(negedge clk);
    rsp_ready = 1'b0;
    #1 chk("t4_r_credit_free", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_payload_instruction = '0;
    pulse(32'h0000_0222);
    pulse(32'h0000_0333);
    drain();
    // T4b: pending queue full after four A-cmds
    rsp_ready = 1'b0;
    repeat (4) send(A_INSN);
    cmd_valid = 1'b1;
    cmd_payload_instruction = A_INSN;
    #1 chk("t4_full", cmd_ready, 0);
    chk("t4_full_stat", stat_outstanding, 4);
    @(negedge clk);
    rsp_ready = 1'b1;
    #1 chk("t4_full_pop_same_cycle", cmd_ready, 0);
    @(negedge clk);
    #1 chk("t4_after_pop", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_payload_instruction = '0;
    drain();
    // T5: watchdog timeout then late spurious result
    @(negedge clk);
    send(R_INSN);
    n = 0;
    #1;
    while (!rsp_valid && n < 40) begin @(negedge clk); #1; n++; end
    chk("t5_stall_cycles", n, TMO);
    chk("t5_payload", rsp_payload_output, 32'hDEADBEEF);
    @(negedge clk);
    core_res_valid = 1'b1;
    core_res_data = 32'h0000_0BAD;
    #1;
    chk("t5_err_timeout", err_timeout, 1);
    chk("t5_spur_before", err_spurious, 0);
    @(negedge clk);
    core_res_valid = 1'b0;
    core_res_data = '0;
    #1;
    chk("t5_err_spurious", err_spurious, 1);
    chk("t5_stat0", stat_outstanding, 0);
    // T6: reset mid-operation
    @(negedge clk);
    rsp_ready = 1'b0;
    repeat (3) send(A_INSN);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("t6_rsp_valid", rsp_valid, 0);
    chk("t6_payload", rsp_payload_output, 0);
    chk("t6_stat", stat_outstanding, 0);
    chk("t6_err_spurious", err_spurious, 0);
    chk("t6_err_timeout", err_timeout, 0);
    chk("t6_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    rsp_ready = 1'b1;
    send(A_INSN);
    #1;
    chk("t6_fresh_valid", rsp_valid, 1);
    chk("t6_fresh_stat", stat_outstanding, 1);
    @(negedge clk);
    #1 chk("t6_fresh_done", stat_outstanding, 0);
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
